// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential 16-bit binary to 5-digit BCD converter (double-dabble), one
//   bit per clock. A start accepted in IDLE produces a result and a one-cycle
//   done pulse exactly 16 edges later, whatever the data value.
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   en    : start request, sampled only in IDLE
//   bin   : 16-bit unsigned value, captured on the accepting edge
//   bcd   : five packed BCD digits ([19:16] ten-thousands .. [3:0] units)
//   busy  : high while converting
//   done  : single-cycle completion pulse
// -----------------------------------------------------------------------------
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] shift_reg;
    logic [19:0] scratch;
    logic [3:0]  count;

    // Scratch digits after the add-3 correction, and the result of shifting
    // {corrected scratch, shift register} left by one.
    logic [19:0] corrected;
    logic [19:0] scratch_shifted;
    logic        last_shift;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        corrected = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_shifted = {corrected[18:0], shift_reg[15]};
        last_shift      = (count == 4'd15);
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all datapath registers are reset, not just the FSM, because an
    // aborted conversion must leave bcd at zero and no stale scratch behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        count     <= '0;
                    end
                end
                CONVERT: begin
                    shift_reg <= {shift_reg[14:0], 1'b0};
                    scratch   <= scratch_shifted;
                    count     <= count + 4'd1;
                    // The 16th shift's result goes straight to the output.
                    if (last_shift) begin
                        bcd <= scratch_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
